// File: rtl/image_stream_reader.sv
// Raster-order frame reader: 1-cycle RAM to valid/ready pixel stream with row blanking.
// Optional STREAM_READER_MARKERS_EN adds sof_o/eol_o pixel markers.
module image_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int HBLANK     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     ready_i,
  output logic                     mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  input  logic [DATA_WIDTH-1:0]    mem_data_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     done_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic [$clog2(IMG_W)-1:0] col_o,
`ifdef STREAM_READER_MARKERS_EN
  output logic                     sof_o,
  output logic                     eol_o,
`endif
  output logic                     busy_o,
  output logic                     frame_done_o
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int HW = $clog2(HBLANK + 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
  localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
  localparam logic [HW-1:0] HB_LAST = HW'(HBLANK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_HBLANK, S_FINISH
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
`ifdef STREAM_READER_MARKERS_EN
    logic                  sof;
    logic                  eol;
`endif
  } ent_t;

  state_t state_q, state_d;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [HW-1:0] hb_q;
  logic infl_q;
  ent_t tag_q, push_e, e0_q, e1_q;
  logic [1:0] cnt_q;
  logic pop, rd;
  logic [2:0] pend;

  assign done_o = (cnt_q != 2'd0);
  assign pop = done_o && ready_i;
  // A pop this cycle frees a slot, which keeps reads back-to-back.
  assign pend = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};

  always_comb begin
    push_e = tag_q;
    push_e.data = mem_data_i;
  end

  // Frame sequencing: next state and read strobe.
  always_comb begin
    state_d = state_q;
    rd = 1'b0;
    frame_done_o = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (start_i) state_d = S_READ;
      S_READ:
        if (pend < 3'd2) begin
          rd = 1'b1;
          if (col_q == LAST_C) state_d = S_DRAIN;
        end
      S_DRAIN:
        if (cnt_q == 2'd0 && !infl_q)
          state_d = (row_q == LAST_R) ? S_FINISH : S_HBLANK;
      S_HBLANK:
        if (hb_q == HB_LAST) state_d = S_READ;
      S_FINISH: begin
        frame_done_o = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Read-side counters and the tag of the read in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
      hb_q   <= '0;
      infl_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      infl_q <= rd;
      if (state_q == S_IDLE && start_i) begin
        row_q  <= '0;
        col_q  <= '0;
        addr_q <= '0;
        hb_q   <= '0;
      end
      if (rd) begin
        addr_q    <= addr_q + 1'b1;
        tag_q.row <= row_q;
        tag_q.col <= col_q;
`ifdef STREAM_READER_MARKERS_EN
        tag_q.sof <= (row_q == '0) && (col_q == '0);
        tag_q.eol <= (col_q == LAST_C);
`endif
        if (col_q != LAST_C) col_q <= col_q + 1'b1;
      end
      if (state_q == S_HBLANK) begin
        if (hb_q == HB_LAST) begin
          hb_q  <= '0;
          row_q <= row_q + 1'b1;
          col_q <= '0;
        end else begin
          hb_q <= hb_q + 1'b1;
        end
      end
    end
  end

  // Two-entry output FIFO; e0 is always the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
      if (pop) e0_q <= e1_q;
      if (infl_q) begin
        if (cnt_q == 2'd2 || (cnt_q == 2'd1 && !pop)) e1_q <= push_e;
        else e0_q <= push_e;
      end
    end
  end

  assign mem_rd_en_o = rd;
  assign mem_addr_o  = addr_q;
  assign data_o      = e0_q.data;
  assign row_o       = e0_q.row;
  assign col_o       = e0_q.col;
  assign busy_o      = (state_q != S_IDLE);
`ifdef STREAM_READER_MARKERS_EN
  assign sof_o = done_o & e0_q.sof;
  assign eol_o = done_o & e0_q.eol;
`endif

endmodule

// File: tb/tb_image_stream_reader.sv
// Directed bench for image_stream_reader on a 4x3 frame with RAM[i]=i.
// Define STREAM_READER_MARKERS_EN to also check sof_o/eol_o.
module tb_image_stream_reader;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int HB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic ready_i = 1'b0;
  logic mem_rd_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i = '0;
  logic [DW-1:0] data_o;
  logic done_o, busy_o, frame_done_o;
  logic [1:0] row_o, col_o;
`ifdef STREAM_READER_MARKERS_EN
  logic sof_o, eol_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en_o) mem_data_i <= DW'(mem_addr_o);

  image_stream_reader #(
    .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H),
    .ADDR_WIDTH(AW), .HBLANK(HB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .ready_i(ready_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i), .data_o(data_o),
    .done_o(done_o), .row_o(row_o), .col_o(col_o),
`ifdef STREAM_READER_MARKERS_EN
    .sof_o(sof_o), .eol_o(eol_o),
`endif
    .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(busy_o), 0);
    chk({pfx, "_done"}, 32'(done_o), 0);
    chk({pfx, "_rd"}, 32'(mem_rd_en_o), 0);
    chk({pfx, "_addr"}, 32'(mem_addr_o), 0);
    chk({pfx, "_data"}, 32'(data_o), 0);
    chk({pfx, "_row"}, 32'(row_o), 0);
    chk({pfx, "_col"}, 32'(col_o), 0);
    chk({pfx, "_fd"}, 32'(frame_done_o), 0);
  endtask

  // mode 0: ready high, 1: ready toggles, 2: 10-cycle stall at pixel 5
  task automatic run_frame(input int mode, input bit mid_start,
                           input bit abort);
    int exp_idx = 0;
    int out_cnt = 0;
    int idle = 0;
    int stall = 0;
    bit prev_acc = 1'b0;
    bit first_rd = 1'b1;
    bit seen_done = 1'b0;
    bit fin = 1'b0;
    bit stalling;
    logic rd_s, acc;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int cyc = 1; cyc < 300 && !fin; cyc++) begin
      if (abort && exp_idx == 6) begin
        rst_n = 1'b0;
        ready_i = 1'b0;
        tick;
        chk_zero("abort");
        rst_n = 1'b1;
        repeat (4) begin
          tick;
          chk("abort_no_fd", 32'(frame_done_o), 0);
        end
        chk("abort_idle", 32'(busy_o), 0);
        return;
      end
      stalling = (mode == 2) && (exp_idx == 5) && (stall < 10) &&
                 (stall > 0 || done_o);
      if (stalling) begin
        ready_i = 1'b0;
        stall++;
        chk("stall_done", 32'(done_o), 1);
        chk("stall_data", 32'(data_o), 5);
        chk("stall_row", 32'(row_o), 1);
        chk("stall_col", 32'(col_o), 1);
      end else if (mode == 1) begin
        ready_i = cyc[0];
      end else begin
        ready_i = 1'b1;
      end
      start_i = mid_start && (cyc == 8);
      #1;
      rd_s = mem_rd_en_o;
      acc = done_o && ready_i;
      if (rd_s && first_rd) begin
        chk("first_addr", 32'(mem_addr_o), 0);
        first_rd = 1'b0;
      end
      if (rd_s)
        chk("pending_le2", 32'(out_cnt - int'(acc) + 1 <= 2), 1);
      if (stalling && out_cnt == 2)
        chk("stall_no_rd", 32'(rd_s), 0);
      if (done_o && !seen_done) begin
        seen_done = 1'b1;
        if (mode == 0) chk("latency", 32'(cyc), 3);
      end
      if (acc) begin
        chk("data", 32'(data_o), 32'(exp_idx));
        chk("row", 32'(row_o), 32'(exp_idx / W));
        chk("col", 32'(col_o), 32'(exp_idx % W));
        if (mode == 0) begin
          if (exp_idx % W == 0 && exp_idx > 0)
            chk("hblank_gap", 32'(idle >= HB), 1);
          else if (exp_idx % W != 0)
            chk("row_contig", 32'(prev_acc), 1);
        end
`ifdef STREAM_READER_MARKERS_EN
        chk("sof", 32'(sof_o), 32'(exp_idx == 0));
        chk("eol", 32'(eol_o), 32'(exp_idx % W == W - 1));
`endif
        exp_idx++;
      end
      idle = done_o ? 0 : idle + 1;
      prev_acc = acc;
      if (frame_done_o) begin
        chk("fd_pixels", 32'(exp_idx), 32'(W * H));
        fin = 1'b1;
      end
      tick;
      out_cnt += int'(rd_s) - int'(acc);
    end
    chk("frame_finished", 32'(fin), 1);
    chk("post_busy", 32'(busy_o), 0);
    chk("post_done", 32'(done_o), 0);
    chk("post_fd", 32'(frame_done_o), 0);
    ready_i = 1'b0;
    start_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) tick;
    chk_zero("reset");
    rst_n = 1'b1;
    tick;
    chk("idle_busy", 32'(busy_o), 0);
    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
